ft_dmem_ctrl: RTL
=================

FT_DMEM_CTRL -- requirements
Module: ft_dmem_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0010_0000, byte address of the first SRAM word.
REQ-002 SHALL have parameter AW, default 12, SRAM word-address width (4 KiW = 16 KiB window).
REQ-003 SHALL have port clk_i  in  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset; one clock; reset asynchronous, active-low.
REQ-005 SHALL have ports data_req_i in 1, data_gnt_o out 1, data_rvalid_o out 1: core data-port handshake.
REQ-006 SHALL have ports data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32: request fields.
REQ-007 SHALL have ports data_rdata_o out 32, data_err_o out 1: response fields.
REQ-008 SHALL have port hold_i  in  1  recovery freeze from the FT module; blocks new grants.
REQ-009 SHALL have ports sram_req_o out 1, sram_we_o out 1, sram_be_o out 4, sram_addr_o out AW, sram_wdata_o out 32, sram_rdata_i in 32: single-port synchronous SRAM, read data valid one cycle after sram_req_o.
REQ-010 SHALL have ports busy_o out 1 (response outstanding) and err_cnt_o out 8 (error responses seen).

Function
REQ-011 data_gnt_o SHALL be combinational: data_req_i & ~hold_i; grant permitted in IDLE and RESP (back-to-back).
REQ-012 In-range test: BASE_ADDR <= data_addr_i < BASE_ADDR + 4*2^AW; addr[1:0] ignored.
REQ-013 On grant with in-range address, sram_req_o=1 same cycle, sram_addr_o=(data_addr_i-BASE_ADDR)>>2, sram_we_o/be/wdata copied from request.
REQ-014 On grant with out-of-range address, sram_req_o SHALL stay 0.
REQ-015 FSM states IDLE, RESP, ERR; IDLE/RESP/ERR go to RESP on in-range grant, ERR on out-of-range grant, else IDLE.
REQ-016 In RESP: data_rvalid_o=1, data_err_o=0, data_rdata_o=sram_rdata_i for reads, 32'h0 for writes.
REQ-017 In ERR: data_rvalid_o=1, data_err_o=1, data_rdata_o=32'h0; no SRAM write occurred.
REQ-018 Latency SHALL be exactly one cycle grant-to-rvalid; at most one response outstanding; sustained throughput one access per cycle.
REQ-019 hold_i asserted while a response is outstanding SHALL NOT suppress that response; only new grants blocked.
REQ-020 err_cnt_o SHALL increment by one per cycle with data_err_o=1, saturating at 8'hFF.
REQ-021 busy_o SHALL equal (state != IDLE).

Reset
REQ-022 On rst_ni low, state=IDLE, data_rvalid_o=0, data_err_o=0, data_rdata_o=0, err_cnt_o=0, busy_o=0, immediately (asynchronous).
REQ-023 Reset asserted mid-access SHALL drop the pending response; no rvalid after reset release.
REQ-024 sram_req_o SHALL be 0 while rst_ni low.

Configuration
REQ-025 Macro FT_DMEM_PARITY_EN SHALL add ports sram_par_o out 4 and sram_par_i in 4 (even parity per byte).
REQ-026 With FT_DMEM_PARITY_EN: writes store parity of enabled bytes; reads recompute over all bytes; mismatch gives data_err_o=1 in RESP, rdata still returned, err_cnt_o increments.
REQ-027 Without FT_DMEM_PARITY_EN: parity ports absent, RESP never sets data_err_o.

Structure
REQ-028 Package ft_pkg SHALL hold the state enum dmem_state_e, the default BASE_ADDR constant and the parity function.
REQ-029 One sub-module ft_dmem_parity (4-lane parity gen/check), instantiated only under FT_DMEM_PARITY_EN.

Verification
REQ-030 Write 32'hDEAD_BEEF be=4'hF to 32'h0010_0004, then read it -> sram_addr_o=1 both times; read rvalid next cycle, rdata=32'hDEAD_BEEF, err=0.
REQ-031 Read 32'h0000_0000 (out of range) -> gnt=1, sram_req_o=0, next cycle rvalid=1, err=1, rdata=0, err_cnt_o=1.
REQ-032 Four back-to-back reads with req held high -> four grants in four cycles, four rvalids in consecutive following cycles, busy_o high throughout.
REQ-033 hold_i raised the cycle after a grant -> pending rvalid still delivered; gnt=0 while hold_i=1; resumes after release.
REQ-034 rst_ni pulled low in RESP -> rvalid=0 immediately, no rvalid after release, err_cnt_o=0.
REQ-035 (FT_DMEM_PARITY_EN) write 32'h0000_00FF, flip sram_par_i[0] on read -> rvalid=1, err=1, rdata=32'h0000_00FF, err_cnt_o increments.

Source files
------------

// File: rtl/ft_dmem.sv
// rtl/ft_dmem.sv - response latency constant for the data-memory controller
package ft_dmem_slot_pkg;
  localparam int unsigned DMEM_RESP_LATENCY = 1;
endpackage

// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared types, constants and parity helper for the data-memory controller
package ft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    ERR  = 2'd2
  } dmem_state_e;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0010_0000;

  // Even parity bit per byte lane: the bit makes the 9-bit group have an even number of ones.
  function automatic logic [3:0] byte_parity(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/ft_dmem_parity.sv
// rtl/ft_dmem_parity.sv - 4-lane even-parity generator and checker for SRAM words
module ft_dmem_parity
  import ft_pkg::*;
(
  input  logic [31:0] wdata_i,
  output logic [3:0]  par_o,
  input  logic [31:0] rdata_i,
  input  logic [3:0]  par_i,
  output logic        err_o
);

  // Parity for every lane is produced; the SRAM byte enables decide which lanes get stored.
  assign par_o = byte_parity(wdata_i);

  // All four lanes are checked on read, regardless of the original write's byte enables.
  assign err_o = |(byte_parity(rdata_i) ^ par_i);

endmodule

// File: rtl/ft_dmem_ctrl.sv
// rtl/ft_dmem_ctrl.sv - core data port to single-port SRAM bridge; optional parity via FT_DMEM_PARITY_EN
module ft_dmem_ctrl
  import ft_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR,
  parameter int unsigned AW        = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          data_req_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,
  input  logic          hold_i,
  output logic          sram_req_o,
  output logic          sram_we_o,
  output logic [3:0]    sram_be_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_wdata_o,
  input  logic [31:0]   sram_rdata_i,
`ifdef FT_DMEM_PARITY_EN
  output logic [3:0]    sram_par_o,
  input  logic [3:0]    sram_par_i,
`endif
  output logic          busy_o,
  output logic [7:0]    err_cnt_o
);

  // Window size in bytes, kept 33 bits wide so a window ending at 4 GiB cannot wrap.
  localparam logic [32:0] WINDOW = 33'(1) << (AW + 2);

  dmem_state_e state_q, state_d;
  logic        we_q, we_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        grant;
  logic        in_range;
  logic [31:0] offset;
  logic        par_err;

  assign grant    = data_req_i & ~hold_i;
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = (data_addr_i >= BASE_ADDR) && ({1'b0, offset} < WINDOW);

  assign data_gnt_o   = grant;
  assign sram_req_o   = grant & in_range & rst_ni;
  assign sram_we_o    = data_we_i;
  assign sram_be_o    = data_be_i;
  assign sram_addr_o  = offset[AW+1:2];
  assign sram_wdata_o = data_wdata_i;

`ifdef FT_DMEM_PARITY_EN
  ft_dmem_parity u_parity (
    .wdata_i (data_wdata_i),
    .par_o   (sram_par_o),
    .rdata_i (sram_rdata_i),
    .par_i   (sram_par_i),
    .err_o   (par_err)
  );
`else
  assign par_err = 1'b0;
`endif

  // State, access direction and error counter registers; reset drops any pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next state from the current grant plus response outputs driven from the registered state.
  always_comb begin
    state_d       = IDLE;
    we_d          = we_q;
    data_rvalid_o = 1'b0;
    data_err_o    = 1'b0;
    data_rdata_o  = 32'h0;
    err_cnt_d     = err_cnt_q;

    if (grant) begin
      state_d = in_range ? RESP : ERR;
      we_d    = data_we_i;
    end

    unique case (state_q)
      RESP: begin
        data_rvalid_o = 1'b1;
        if (!we_q) begin
          data_rdata_o = sram_rdata_i;
          data_err_o   = par_err;
        end
      end
      ERR: begin
        data_rvalid_o = 1'b1;
        data_err_o    = 1'b1;
      end
      default: begin
        data_rvalid_o = 1'b0;
      end
    endcase

    if (data_err_o && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign err_cnt_o = err_cnt_q;

endmodule
